rgb_to_gray_pipe: RTL and testbench
===================================

Name: rgb_to_gray_pipe

Overview:
Parametrised, pipelined successor to the combinational RGB-to-grey converter that feeds the GMM background model. It converts one RGB pixel per beat to a single luminance sample and offers four selectable conversion modes, including programmable fixed-point weights. It uses a valid/ready streaming handshake with full back-pressure, and carries start-of-packet and end-of-packet markers. Mode and coefficients are frame-coherent, and the block reports the pixel count of each completed frame.

Parameters:
DATA_WIDTH, 8, width of each colour channel and of the grey output
COEF_WIDTH, 8, width of each weight coefficient; weights are unsigned fixed-point with COEF_WIDTH fractional bits
CNT_WIDTH, 20, width of the per-frame pixel counter

Ports:
clk  in  1  single clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
r_data_in  in  DATA_WIDTH  red channel
g_data_in  in  DATA_WIDTH  green channel
b_data_in  in  DATA_WIDTH  blue channel
sop_in  in  1  first pixel of a frame
eop_in  in  1  last pixel of a frame
valid_in  in  1  input beat valid
ready_out  out  1  block can accept the input beat
mode  in  2  conversion mode; sampled only at sop
coef_r, coef_g, coef_b  in  COEF_WIDTH each  weights for mode 1; sampled only at sop
data_out  out  DATA_WIDTH  grey result
sop_out  out  1  sop marker aligned with data_out
eop_out  out  1  eop marker aligned with data_out
valid_out  out  1  output beat valid
ready_in  in  1  downstream accepts the output beat
frame_pixels  out  CNT_WIDTH  pixel count of the last completed frame
frame_done  out  1  one-cycle pulse when frame_pixels updates

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: all pipeline valid bits, valid_out, data_out, sop_out, eop_out, frame_pixels and frame_done are 0. The active mode register is 0 and the active coefficients are 0.
- Transfers: an input transfer occurs when valid_in && ready_out. An output transfer occurs when valid_out && ready_in.
- Pipeline: three register stages (S1 capture/latch, S2 multiply/sum, S3 round/saturate). Latency is 3 cycles from input transfer to valid_out when there is no stall.
- Stage advance rule: a stage loads when it is empty or when the following stage is advancing. Bubbles collapse.
- ready_out = !S1_valid || S1_advancing. It is purely a function of register state and ready_in.
- Stall: while ready_in = 0 and valid_out = 1, data_out, sop_out and eop_out hold stable and no beat is lost or duplicated. Up to 3 beats can be in flight.
- Mode/coefficient latch: on an input transfer with sop_in = 1, mode and coef_* are captured into active registers and apply to that beat and every later beat until the next sop. Changes on mode or coef_* at any other time have no effect.
- Beats accepted before the first sop use the reset values (mode 0).
- Mode 0, approximate: (R + 2G + B + 2) >> 2. Intermediate width is DATA_WIDTH+2. The result never exceeds max.
- Mode 1, weighted: sum = R*cr + G*cg + B*cb, computed at full width DATA_WIDTH+COEF_WIDTH+2. Result = (sum + 2^(COEF_WIDTH-1)) >> COEF_WIDTH, saturated to 2^DATA_WIDTH-1.
- Mode 2: max(R, G, B).
- Mode 3: G passthrough.
- Frame counter: it increments on every input transfer. On a transfer with sop_in = 1 the counter restarts at 1.
- Frame end: on a transfer with eop_in = 1, frame_pixels is loaded with the count including that beat, and frame_done pulses for one cycle in the following cycle.
- sop and eop on the same beat: a 1-pixel frame. The latch applies, frame_pixels = 1 and frame_done pulses.
- sop without a preceding eop: the counter restarts silently and frame_pixels is not updated.
- Counter overflow: the counter saturates at 2^CNT_WIDTH-1.
- Reset mid-operation: in-flight beats are discarded and all outputs return to their reset values on the next edge. The first beat after reset is accepted in the cycle reset deasserts.

Test Plan:
- Mode 0, no stall: sop beat R=100, G=50, B=10, ready_in=1 held → data_out=53 with valid_out exactly 3 cycles after the transfer, sop_out=1.
- Mode 1 BT.601: coefs 77/150/29 at sop. Inputs (255,255,255) → 255, and (0,0,0) → 0. Then coefs 255/255/255 with (255,255,255) → saturates to 255.
- Mode 2 then mode 3: input (12,200,7) → 200. Mode is changed to 3 mid-frame and has no effect until the next sop. After the next sop, input (12,201,7) → 201.
- Back-pressure: 10-beat stream with ready_in toggled in the pattern 1,0,0,1,… → all 10 outputs appear in order with no loss or duplication, and data is stable during stalls. ready_out drops after 3 beats are held.
- Framing: a 6-beat frame (sop on beat 1, eop on beat 6) → frame_pixels=6 and a single frame_done pulse. A following single beat with sop and eop together → frame_pixels=1.
- Reset: assert reset with 2 beats in flight → valid_out=0 next cycle and frame_pixels=0. No stale beat appears after reset deasserts.

Source files
------------

// File: rtl/rgb_to_gray_pipe_if.sv
// Streaming bundle for rgb_to_gray_pipe: pixel input side, grey output side,
// frame configuration and frame statistics.
interface rgb_to_gray_pipe_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned COEF_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 20
);
    logic [DATA_WIDTH-1:0] r_data_in;
    logic [DATA_WIDTH-1:0] g_data_in;
    logic [DATA_WIDTH-1:0] b_data_in;
    logic                  sop_in;
    logic                  eop_in;
    logic                  valid_in;
    logic                  ready_out;
    logic [1:0]            mode;
    logic [COEF_WIDTH-1:0] coef_r;
    logic [COEF_WIDTH-1:0] coef_g;
    logic [COEF_WIDTH-1:0] coef_b;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  sop_out;
    logic                  eop_out;
    logic                  valid_out;
    logic                  ready_in;
    logic [CNT_WIDTH-1:0]  frame_pixels;
    logic                  frame_done;

    // Converter side
    modport slave (
        input  r_data_in, g_data_in, b_data_in, sop_in, eop_in, valid_in,
        input  mode, coef_r, coef_g, coef_b, ready_in,
        output ready_out, data_out, sop_out, eop_out, valid_out,
        output frame_pixels, frame_done
    );

    // Pixel source / grey sink side
    modport master (
        output r_data_in, g_data_in, b_data_in, sop_in, eop_in, valid_in,
        output mode, coef_r, coef_g, coef_b, ready_in,
        input  ready_out, data_out, sop_out, eop_out, valid_out,
        input  frame_pixels, frame_done
    );
endinterface

// File: rtl/rgb_to_gray_pipe.sv
// Three-stage RGB to grey converter with valid/ready back-pressure,
// frame-coherent mode/weight selection and per-frame pixel counting.
module rgb_to_gray_pipe #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned COEF_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 20
) (
    input  logic               clk,
    input  logic               reset,
    rgb_to_gray_pipe_if.slave  bus
);
    localparam int unsigned SUM_W = DATA_WIDTH + COEF_WIDTH + 2;

    localparam logic [1:0] MODE_APPROX = 2'd0;
    localparam logic [1:0] MODE_WEIGHT = 2'd1;
    localparam logic [1:0] MODE_MAX    = 2'd2;

    localparam logic [SUM_W-1:0] COEF_HALF = SUM_W'(1) << (COEF_WIDTH - 1);
    localparam logic [SUM_W-1:0] DATA_MAX  = SUM_W'({DATA_WIDTH{1'b1}});

    // Active frame configuration
    logic [1:0]            act_mode;
    logic [COEF_WIDTH-1:0] act_cr, act_cg, act_cb;

    // Stage registers
    logic                  s1_valid, s1_sop, s1_eop;
    logic [DATA_WIDTH-1:0] s1_r, s1_g, s1_b;
    logic [1:0]            s1_mode;
    logic [COEF_WIDTH-1:0] s1_cr, s1_cg, s1_cb;
    logic                  s2_valid, s2_sop, s2_eop;
    logic [1:0]            s2_mode;
    logic [SUM_W-1:0]      s2_sum;
    logic                  s3_valid, s3_sop, s3_eop;
    logic [DATA_WIDTH-1:0] s3_data;

    // Frame statistics
    logic [CNT_WIDTH-1:0]  cnt, cnt_nxt_c, fp_q;
    logic                  done_q;

    logic s1_load_c, s2_load_c, s3_load_c, in_xfer_c;
    logic [DATA_WIDTH-1:0] max_rg_c, max_c, res_c;
    logic [SUM_W-1:0]      sum_c, rnd_c;

    // A stage loads when empty or when its contents move downstream
    assign s3_load_c = !s3_valid || bus.ready_in;
    assign s2_load_c = !s2_valid || s3_load_c;
    assign s1_load_c = !s1_valid || s2_load_c;
    assign in_xfer_c = bus.valid_in && s1_load_c;

    assign bus.ready_out    = s1_load_c;
    assign bus.valid_out    = s3_valid;
    assign bus.data_out     = s3_data;
    assign bus.sop_out      = s3_sop;
    assign bus.eop_out      = s3_eop;
    assign bus.frame_pixels = fp_q;
    assign bus.frame_done   = done_q;

    // Latch mode and weights on the sop beat of each frame
    always_ff @(posedge clk) begin
        if (reset) begin
            act_mode <= '0;
            act_cr   <= '0;
            act_cg   <= '0;
            act_cb   <= '0;
        end else if (in_xfer_c && bus.sop_in) begin
            act_mode <= bus.mode;
            act_cr   <= bus.coef_r;
            act_cg   <= bus.coef_g;
            act_cb   <= bus.coef_b;
        end
    end

    // S1: capture pixel with the configuration that applies to it
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sop   <= 1'b0;
            s1_eop   <= 1'b0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
            s1_mode  <= '0;
            s1_cr    <= '0;
            s1_cg    <= '0;
            s1_cb    <= '0;
        end else if (s1_load_c) begin
            s1_valid <= bus.valid_in;
            if (bus.valid_in) begin
                s1_sop  <= bus.sop_in;
                s1_eop  <= bus.eop_in;
                s1_r    <= bus.r_data_in;
                s1_g    <= bus.g_data_in;
                s1_b    <= bus.b_data_in;
                s1_mode <= bus.sop_in ? bus.mode   : act_mode;
                s1_cr   <= bus.sop_in ? bus.coef_r : act_cr;
                s1_cg   <= bus.sop_in ? bus.coef_g : act_cg;
                s1_cb   <= bus.sop_in ? bus.coef_b : act_cb;
            end
        end
    end

    // Mode-dependent full-width sum (or selected channel) for S2
    always_comb begin
        max_rg_c = (s1_r > s1_g) ? s1_r : s1_g;
        max_c    = (max_rg_c > s1_b) ? max_rg_c : s1_b;
        sum_c    = '0;
        case (s1_mode)
            MODE_APPROX: sum_c = SUM_W'(s1_r) + (SUM_W'(s1_g) << 1) + SUM_W'(s1_b);
            MODE_WEIGHT: sum_c = SUM_W'(s1_r) * SUM_W'(s1_cr)
                               + SUM_W'(s1_g) * SUM_W'(s1_cg)
                               + SUM_W'(s1_b) * SUM_W'(s1_cb);
            MODE_MAX:    sum_c = SUM_W'(max_c);
            default:     sum_c = SUM_W'(s1_g);
        endcase
    end

    // S2: multiply/sum register
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_sop   <= 1'b0;
            s2_eop   <= 1'b0;
            s2_mode  <= '0;
            s2_sum   <= '0;
        end else if (s2_load_c) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sop  <= s1_sop;
                s2_eop  <= s1_eop;
                s2_mode <= s1_mode;
                s2_sum  <= sum_c;
            end
        end
    end

    // Round and saturate the sum back to a grey sample
    always_comb begin
        rnd_c = '0;
        res_c = '0;
        case (s2_mode)
            MODE_APPROX: begin
                rnd_c = s2_sum + SUM_W'(2);
                res_c = DATA_WIDTH'(rnd_c >> 2);
            end
            MODE_WEIGHT: begin
                rnd_c = (s2_sum + COEF_HALF) >> COEF_WIDTH;
                res_c = (rnd_c > DATA_MAX) ? '1 : DATA_WIDTH'(rnd_c);
            end
            default: res_c = DATA_WIDTH'(s2_sum);
        endcase
    end

    // S3: output register, held while downstream stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            s3_valid <= 1'b0;
            s3_sop   <= 1'b0;
            s3_eop   <= 1'b0;
            s3_data  <= '0;
        end else if (s3_load_c) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_sop  <= s2_sop;
                s3_eop  <= s2_eop;
                s3_data <= res_c;
            end
        end
    end

    // Count including the current beat; sop restarts, saturates at all-ones
    always_comb begin
        if (bus.sop_in) begin
            cnt_nxt_c = CNT_WIDTH'(1);
        end else if (&cnt) begin
            cnt_nxt_c = cnt;
        end else begin
            cnt_nxt_c = cnt + CNT_WIDTH'(1);
        end
    end

    // Per-frame pixel counter and completed-frame report
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            fp_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (in_xfer_c) begin
                cnt <= cnt_nxt_c;
                if (bus.eop_in) begin
                    fp_q   <= cnt_nxt_c;
                    done_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rgb_to_gray_pipe.sv
// Directed bench for rgb_to_gray_pipe with a reference model and a per-cycle
// output monitor.
module tb_rgb_to_gray_pipe;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;
    localparam int unsigned NW = 20;

    typedef struct {
        int d;
        bit s;
        bit e;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    rgb_to_gray_pipe_if #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .CNT_WIDTH(NW)) bus ();

    rgb_to_gray_pipe #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .CNT_WIDTH(NW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   m_mode, m_cr, m_cg, m_cb, m_cnt;
    int   exp_fp, done_cnt, n_out, last_out;
    bit   exp_done, rst_seen, hold;
    int   held_d;
    bit   held_s, held_e;
    bit   bp_en, ri_force;
    int   bp_ph;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Grey value straight from the conversion rules
    function automatic int gray_ref(input int md, input int r, input int g, input int b,
                                    input int cr, input int cg, input int cb);
        int s;
        int maxv;
        maxv = (1 << DW) - 1;
        case (md)
            0: s = (r + 2 * g + b + 2) / 4;
            1: begin
                s = (r * cr + g * cg + b * cb + (1 << (CW - 1))) / (1 << CW);
                if (s > maxv) s = maxv;
            end
            2: begin
                s = r;
                if (g > s) s = g;
                if (b > s) s = b;
            end
            default: s = g;
        endcase
        return s;
    endfunction

    // Per-cycle monitor: compares outputs, then advances the model
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            chk("frame_done", bus.frame_done, exp_done);
            chk("frame_pixels", bus.frame_pixels, exp_fp);
            if (bus.frame_done) done_cnt++;
            if (rst_seen) begin
                chk("valid_out_reset", bus.valid_out, 0);
                chk("data_out_reset", bus.data_out, 0);
            end
            if (hold) begin
                chk("stall_valid", bus.valid_out, 1);
                chk("stall_data", bus.data_out, held_d);
                chk("stall_sop", bus.sop_out, held_s);
                chk("stall_eop", bus.eop_out, held_e);
            end
            if (bus.valid_out && bus.ready_in) begin
                if (q.size() == 0) begin
                    chk("stale_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_data", bus.data_out, e.d);
                    chk("out_sop", bus.sop_out, e.s);
                    chk("out_eop", bus.eop_out, e.e);
                end
                last_out = bus.data_out;
                n_out++;
            end
            hold     = bus.valid_out && !bus.ready_in;
            held_d   = bus.data_out;
            held_s   = bus.sop_out;
            held_e   = bus.eop_out;
            exp_done = 1'b0;
            rst_seen = reset;
            if (reset) begin
                q.delete();
                exp_fp = 0;
                m_mode = 0; m_cr = 0; m_cg = 0; m_cb = 0; m_cnt = 0;
                hold   = 1'b0;
            end else if (bus.valid_in && bus.ready_out) begin
                if (bus.sop_in) begin
                    m_mode = bus.mode;
                    m_cr = bus.coef_r; m_cg = bus.coef_g; m_cb = bus.coef_b;
                    m_cnt = 1;
                end else if (m_cnt < (1 << NW) - 1) begin
                    m_cnt++;
                end
                e.d = gray_ref(m_mode, bus.r_data_in, bus.g_data_in, bus.b_data_in,
                               m_cr, m_cg, m_cb);
                e.s = bus.sop_in;
                e.e = bus.eop_in;
                q.push_back(e);
                if (bus.eop_in) begin
                    exp_fp   = m_cnt;
                    exp_done = 1'b1;
                end
            end
        end
    endtask

    // Downstream ready: forced level or the 1,0,0 repeating pattern
    task automatic rdy_driver();
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                bus.ready_in = (bp_ph == 0);
                bp_ph = (bp_ph + 1) % 3;
            end else begin
                bus.ready_in = ri_force;
            end
        end
    endtask

    // Present one beat and hold it until accepted (bounded)
    task automatic send(input int r, input int g, input int b, input bit sop, input bit eop,
                        input int md, input int cr, input int cg, input int cb);
        bit acc;
        int n;
        bus.r_data_in = DW'(r);
        bus.g_data_in = DW'(g);
        bus.b_data_in = DW'(b);
        bus.sop_in    = sop;
        bus.eop_in    = eop;
        bus.mode      = 2'(md);
        bus.coef_r    = CW'(cr);
        bus.coef_g    = CW'(cg);
        bus.coef_b    = CW'(cb);
        bus.valid_in  = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.ready_out;
            @(posedge clk);
            n++;
        end
        #1;
        bus.valid_in = 1'b0;
        bus.sop_in   = 1'b0;
        bus.eop_in   = 1'b0;
        if (!acc) chk("accept_timeout", acc, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        int n;
        int n0;
        int d0;
        reset = 1'b1;
        bus.r_data_in = '0; bus.g_data_in = '0; bus.b_data_in = '0;
        bus.sop_in = 1'b0; bus.eop_in = 1'b0; bus.valid_in = 1'b0;
        bus.mode = '0; bus.coef_r = '0; bus.coef_g = '0; bus.coef_b = '0;
        bus.ready_in = 1'b1;
        ri_force = 1'b1; bp_en = 1'b0; bp_ph = 0;
        m_mode = 0; m_cr = 0; m_cg = 0; m_cb = 0; m_cnt = 0;
        exp_fp = 0; exp_done = 1'b0; rst_seen = 1'b0; hold = 1'b0;
        done_cnt = 0; n_out = 0; last_out = -1;
        fork
            monitor();
            rdy_driver();
        join_none

        // Pin the reference model with hand-computed values
        chk("ref_m0", gray_ref(0, 100, 50, 10, 0, 0, 0), 53);
        chk("ref_bt601_white", gray_ref(1, 255, 255, 255, 77, 150, 29), 255);
        chk("ref_bt601_black", gray_ref(1, 0, 0, 0, 77, 150, 29), 0);
        chk("ref_bt601_mid", gray_ref(1, 100, 50, 10, 77, 150, 29), 61);
        chk("ref_sat", gray_ref(1, 255, 255, 255, 255, 255, 255), 255);
        chk("ref_max", gray_ref(2, 12, 200, 7, 0, 0, 0), 200);
        chk("ref_g", gray_ref(3, 12, 201, 7, 0, 0, 0), 201);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid_out", bus.valid_out, 0);
        chk("reset_frame_pixels", bus.frame_pixels, 0);
        reset = 1'b0;

        // Mode 0, no stall: latency and literal result
        send(100, 50, 10, 1, 0, 0, 0, 0, 0);
        n = 1;
        while (!bus.valid_out && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, 3);
        chk("m0_data", bus.data_out, 53);
        chk("m0_sop", bus.sop_out, 1);
        drain();

        // Mode 1 with BT.601 weights, then saturating weights
        send(255, 255, 255, 1, 0, 1, 77, 150, 29);
        send(0, 0, 0, 0, 0, 0, 0, 0, 0);
        send(100, 50, 10, 0, 0, 2, 9, 9, 9);
        drain();
        chk("m1_mid", last_out, 61);
        send(255, 255, 255, 1, 0, 1, 255, 255, 255);
        drain();
        chk("m1_sat", last_out, 255);

        // Mode 2; a mid-frame mode change is ignored until the next sop
        send(12, 200, 7, 1, 0, 2, 0, 0, 0);
        send(250, 201, 7, 0, 0, 3, 0, 0, 0);
        drain();
        chk("mode_hold", last_out, 250);
        send(12, 201, 7, 1, 0, 3, 0, 0, 0);
        drain();
        chk("m3_g", last_out, 201);

        // Back-pressure: fill three stages, then stream under 1,0,0 ready
        ri_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n0 = n_out;
        send(10, 20, 30, 1, 0, 0, 0, 0, 0);
        send(40, 50, 60, 0, 0, 0, 0, 0, 0);
        send(70, 80, 90, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("ready_out_full", bus.ready_out, 0);
        @(posedge clk);
        #1;
        bp_ph = 0;
        bp_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(i * 30 + 5, 255 - i * 20, i * 11, 0, (i == 6), 0, 0, 0, 0);
        end
        drain();
        bp_en = 1'b0;
        ri_force = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("bp_count", n_out - n0, 10);
        chk("bp_frame_pixels", bus.frame_pixels, 10);

        // Framing: 6-beat frame then a 1-pixel frame
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) begin
            send(i * 40, i * 7, 255 - i * 40, (i == 0), (i == 5), 2, 0, 0, 0);
        end
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("frame6_pixels", bus.frame_pixels, 6);
        chk("frame6_done_pulses", done_cnt - d0, 1);
        send(3, 4, 5, 1, 1, 3, 0, 0, 0);
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("frame1_pixels", bus.frame_pixels, 1);
        chk("frame1_done_pulses", done_cnt - d0, 2);

        // Reset with two beats in flight; no stale beat afterwards
        ri_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(1, 2, 3, 1, 0, 0, 0, 0, 0);
        send(4, 5, 6, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid_out", bus.valid_out, 0);
        chk("rst_frame_pixels", bus.frame_pixels, 0);
        reset = 1'b0;
        ri_force = 1'b1;
        n0 = n_out;
        send(30, 60, 90, 1, 1, 0, 0, 0, 0);
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_data", last_out, 60);
        chk("post_reset_count", n_out - n0, 1);
        chk("post_reset_frame", bus.frame_pixels, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
